// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - instruction register, decoder, zero flag and reset synchronizer (optional INSTR_DECODER_PERF_EN counters)
module instruction_decoder #(
    parameter int          RST_HOLD = 4,
    parameter logic [7:0]  NOP_WORD = 8'h80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  pm_data,
    input  logic        alu_zero,
    output logic        sync_reset,
    output logic [7:0]  ir,
    output logic        ir_valid,
    output logic        jmp,
    output logic        jmp_nz,
    output logic [3:0]  jmp_addr,
    output logic        dont_jmp,
    output logic        load,
    output logic        move,
    output logic        alu_op,
    output logic [2:0]  dst,
    output logic [2:0]  src,
    output logic [3:0]  imm
`ifdef INSTR_DECODER_PERF_EN
    ,
    output logic [15:0] instr_count,
    output logic [15:0] jump_taken_count
`endif
);

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

    logic       sync1;
    logic       sync2;
    logic [3:0] hold_cnt;

    // Two-flop synchronizer on the reset release, then hold sync_reset for RST_HOLD more edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            hold_cnt   <= 4'd0;
            sync_reset <= 1'b1;
        end else begin
            sync1 <= 1'b1;
            sync2 <= sync1;
            if (sync2 && sync_reset) begin
                if (hold_cnt == HOLD_LAST) begin
                    sync_reset <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end
        end
    end

    // Instruction register tracks pc: loads the program memory word every edge, NOP filler in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
        end else if (sync_reset) begin
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
        end else begin
            ir       <= pm_data;
            ir_valid <= 1'b1;
        end
    end

    // Decode of the opcode prefix; every strobe and field is zero while ir holds reset filler
    always_comb begin
        load     = 1'b0;
        move     = 1'b0;
        alu_op   = 1'b0;
        jmp      = 1'b0;
        jmp_nz   = 1'b0;
        dst      = 3'd0;
        src      = 3'd0;
        imm      = 4'd0;
        jmp_addr = ir[3:0];
        if (ir_valid) begin
            if (!ir[7]) begin
                load = 1'b1;
                dst  = ir[6:4];
                imm  = ir[3:0];
            end else if (!ir[6]) begin
                move = 1'b1;
                dst  = ir[5:3];
                src  = ir[2:0];
            end else if (!ir[5]) begin
                alu_op = 1'b1;
                src    = ir[4:2];
            end else if (!ir[4]) begin
                jmp = 1'b1;
            end else begin
                jmp_nz = 1'b1;
            end
        end
    end

    // Zero flag captures the ALU result only on ALU instructions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dont_jmp <= 1'b0;
        end else if (sync_reset) begin
            dont_jmp <= 1'b0;
        end else if (alu_op) begin
            dont_jmp <= alu_zero;
        end
    end

`ifdef INSTR_DECODER_PERF_EN
    // Retired-instruction and taken-jump counters, free-running with wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count      <= 16'd0;
            jump_taken_count <= 16'd0;
        end else if (sync_reset) begin
            instr_count      <= 16'd0;
            jump_taken_count <= 16'd0;
        end else begin
            if (ir_valid) begin
                instr_count <= instr_count + 16'd1;
            end
            if (jmp || (jmp_nz && !dont_jmp)) begin
                jump_taken_count <= jump_taken_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - table-driven scoreboard bench for instruction_decoder
module tb_instruction_decoder;

    logic        clk;
    logic        reset_n;
    logic [7:0]  pm_data;
    logic        alu_zero;
    logic        sync_reset;
    logic [7:0]  ir;
    logic        ir_valid;
    logic        jmp;
    logic        jmp_nz;
    logic [3:0]  jmp_addr;
    logic        dont_jmp;
    logic        load;
    logic        move;
    logic        alu_op;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic [3:0]  imm;
`ifdef INSTR_DECODER_PERF_EN
    logic [15:0] instr_count;
    logic [15:0] jump_taken_count;
`endif

    instruction_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pm_data    (pm_data),
        .alu_zero   (alu_zero),
        .sync_reset (sync_reset),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .jmp_addr   (jmp_addr),
        .dont_jmp   (dont_jmp),
        .load       (load),
        .move       (move),
        .alu_op     (alu_op),
        .dst        (dst),
        .src        (src),
        .imm        (imm)
`ifdef INSTR_DECODER_PERF_EN
        ,
        .instr_count      (instr_count),
        .jump_taken_count (jump_taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pm;
        logic       az;
        logic       ld;
        logic       mv;
        logic       al;
        logic       j;
        logic       jnz;
        logic [2:0] dst;
        logic [2:0] src;
        logic [3:0] imm;
        logic [3:0] ja;
        logic       dj;
    } vec_t;

    vec_t vecs[11];
    vec_t sb[$];
    vec_t e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        //         pm     az    ld    mv    al    j     jnz   dst   src   imm    ja     dj
        vecs[0]  = '{8'h35, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 4'h5, 4'h5, 1'b0};
        vecs[1]  = '{8'hE7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 4'h0, 4'h7, 1'b0};
        vecs[2]  = '{8'h9A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 4'h0, 4'hA, 1'b0};
        vecs[3]  = '{8'hC4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 4'h0, 4'h4, 1'b0};
        vecs[4]  = '{8'hF9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 4'h0, 4'h9, 1'b1};
        vecs[5]  = '{8'hC4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 4'h0, 4'h4, 1'b1};
        vecs[6]  = '{8'hF9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 4'h0, 4'h9, 1'b0};
        vecs[7]  = '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 4'hF, 4'hF, 1'b0};
        vecs[8]  = '{8'hC8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 4'h0, 4'h8, 1'b0};
        vecs[9]  = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0, 1'b1};
        vecs[10] = '{8'hF3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 4'h0, 4'h3, 1'b1};

        reset_n  = 1'b0;
        pm_data  = 8'h35;
        alu_zero = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("rst_sync_reset", {15'd0, sync_reset}, 16'd1);
        chk("rst_ir", {8'd0, ir}, 16'h0080);
        chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
        chk("rst_move_gated", {15'd0, move}, 16'd0);
        chk("rst_dont_jmp", {15'd0, dont_jmp}, 16'd0);

        // Release: sync_reset must fall on exactly the 6th edge
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("hold_sync_reset", {15'd0, sync_reset}, (k < 6) ? 16'd1 : 16'd0);
            chk("hold_ir", {8'd0, ir}, 16'h0080);
            chk("hold_ir_valid", {15'd0, ir_valid}, 16'd0);
        end

        // Table-driven instruction stream through the scoreboard
        pm_data = vecs[0].pm;
        sb.push_back(vecs[0]);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            chk("v_ir", {8'd0, ir}, {8'd0, e.pm});
            chk("v_ir_valid", {15'd0, ir_valid}, 16'd1);
            chk("v_load", {15'd0, load}, {15'd0, e.ld});
            chk("v_move", {15'd0, move}, {15'd0, e.mv});
            chk("v_alu_op", {15'd0, alu_op}, {15'd0, e.al});
            chk("v_jmp", {15'd0, jmp}, {15'd0, e.j});
            chk("v_jmp_nz", {15'd0, jmp_nz}, {15'd0, e.jnz});
            chk("v_dst", {13'd0, dst}, {13'd0, e.dst});
            chk("v_src", {13'd0, src}, {13'd0, e.src});
            chk("v_imm", {12'd0, imm}, {12'd0, e.imm});
            chk("v_jmp_addr", {12'd0, jmp_addr}, {12'd0, e.ja});
            chk("v_dont_jmp", {15'd0, dont_jmp}, {15'd0, e.dj});
            alu_zero = vecs[i].az;
            if (i < 10) begin
                pm_data = vecs[i + 1].pm;
                sb.push_back(vecs[i + 1]);
            end
        end
        chk("sb_empty", 16'(sb.size()), 16'd0);

        // Asynchronous reset mid-stream with ir=F3 and flag set
        #2;
        chk("mid_pre_ir", {8'd0, ir}, 16'h00F3);
        chk("mid_pre_dont_jmp", {15'd0, dont_jmp}, 16'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_ir", {8'd0, ir}, 16'h0080);
        chk("mid_jmp_nz", {15'd0, jmp_nz}, 16'd0);
        chk("mid_dont_jmp", {15'd0, dont_jmp}, 16'd0);
        chk("mid_sync_reset", {15'd0, sync_reset}, 16'd1);
        chk("mid_ir_valid", {15'd0, ir_valid}, 16'd0);

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rerel_sync_reset_5", {15'd0, sync_reset}, 16'd1);
        @(negedge clk);
        chk("rerel_sync_reset_6", {15'd0, sync_reset}, 16'd0);

`ifdef INSTR_DECODER_PERF_EN
        begin
            logic [7:0] prog [10];
            prog = '{8'h35, 8'hE7, 8'h9A, 8'hC4, 8'hF9, 8'hE2, 8'h7F, 8'h80, 8'h11, 8'h22};
            alu_zero = 1'b1;
            for (int i = 0; i < 10; i++) begin
                pm_data = prog[i];
                @(negedge clk);
            end
            pm_data = 8'h80;
            @(negedge clk);
            chk("perf_instr_count", instr_count, 16'd10);
            chk("perf_jump_taken", jump_taken_count, 16'd2);
            for (int n = 0; n < 70000 && instr_count != 16'hFFFF; n++) begin
                @(negedge clk);
            end
            chk("perf_instr_max", instr_count, 16'hFFFF);
            @(negedge clk);
            chk("perf_instr_wrap", instr_count, 16'h0000);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
